// File: rtl/ifetch_queue_if.sv
// Fetch-side memory bus and decode-side instruction stream of ifetch_queue.
interface ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Credit-based instruction fetch queue with flush drop counting.
// Define IFQ_BYPASS_EN for zero-latency response bypass to decode.
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    pc_in,
    output logic           stall_out,
    input  logic           flush,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    cnt_t count;
    cnt_t outstanding;
    cnt_t drop_cnt;
    ptr_t tag_wr;
    ptr_t tag_rd;
    ptr_t q_wr;
    ptr_t q_rd;

    logic [31:0] tag_mem [DEPTH];
    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_data  [DEPTH];

    logic        fire;
    logic        rsp;
    logic        dropping;
    logic        keep;
    logic        byp;
    logic        q_push;
    logic        q_pop;
    logic [CW:0] used;

    // Queued plus in-flight entries must fit so a response never finds the queue full.
    assign used = {1'b0, count} + {1'b0, outstanding};

    assign bus.imem_req  = !rst && !flush && (used < LIMIT);
    assign bus.imem_addr = pc_in;
    assign fire          = bus.imem_req & bus.imem_gnt;
    assign stall_out     = rst | (!fire & !flush);

    assign rsp      = bus.imem_rvalid && (outstanding != '0) && !rst;
    assign dropping = drop_cnt != '0;
    assign keep     = rsp && !dropping && !flush;

`ifdef IFQ_BYPASS_EN
    assign byp = keep && (count == '0) && bus.inst_ready;
`else
    assign byp = 1'b0;
`endif

    assign q_push = keep && !byp;
    assign q_pop  = (count != '0) && bus.inst_ready && !rst;

    assign bus.inst_valid = !rst && ((count != '0) || byp);
    assign bus.inst_pc    = byp ? tag_mem[tag_rd] : q_pc[q_rd];
    assign bus.inst_data  = byp ? bus.imem_rdata : q_data[q_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(fire) - cnt_t'(rsp);
            if (fire)
                tag_wr <= tag_wr + ptr_t'(1);
            if (rsp)
                tag_rd <= tag_rd + ptr_t'(1);
            if (flush) begin
                // Everything still in flight after this edge belongs to the old path.
                count    <= '0;
                q_wr     <= '0;
                q_rd     <= '0;
                drop_cnt <= outstanding - cnt_t'(rsp);
            end else begin
                if (rsp && dropping)
                    drop_cnt <= drop_cnt - cnt_t'(1);
                if (q_push)
                    q_wr <= q_wr + ptr_t'(1);
                if (q_pop)
                    q_rd <= q_rd + ptr_t'(1);
                count <= count + cnt_t'(q_push) - cnt_t'(q_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            tag_mem[tag_wr] <= bus.imem_addr;
        if (q_push) begin
            q_pc[q_wr]   <= tag_mem[tag_rd];
            q_data[q_wr] <= bus.imem_rdata;
        end
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving instruction queue entries and the outstanding-fetch limit (power of 2, ≥2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the synchronous, active-high reset.
REQ-004 The block SHALL have port pc_in, input, 32, the fetch address from the PC register.
REQ-005 The block SHALL have port stall_out, output, 1, hold request to the PC register (PC holds when 1).
REQ-006 The block SHALL have port flush, input, 1, a redirect pulse driven from is_branch | is_jump.
REQ-007 The block SHALL have ports imem_req (output, 1, fetch request) and imem_addr (output, 32, fetch address).
REQ-008 The block SHALL have port imem_gnt, input, 1, the memory acceptance of imem_req.
REQ-009 The block SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 32), in-order fetch responses.
REQ-010 The block SHALL have ports inst_valid (output, 1), inst_data (output, 32) and inst_pc (output, 32) toward decode.
REQ-011 The block SHALL have port inst_ready, input, 1, decode acceptance.

Function
REQ-012 Credit: the block SHALL assert imem_req only when (queue_count + outstanding) < DEPTH, flush=0 and rst=0.
REQ-013 imem_addr SHALL equal pc_in combinationally; a fetch is accepted in a cycle where imem_req & imem_gnt.
REQ-014 stall_out SHALL be asserted = !(imem_req & imem_gnt) and flush=0, so the PC advances only on an accepted fetch or a redirect.
REQ-015 Each accepted fetch SHALL push its address into a DEPTH-entry tag FIFO and increment outstanding.
REQ-016 Responses SHALL be in order, one per accepted fetch, at the earliest one cycle after grant; each imem_rvalid decrements outstanding and pops one tag.
REQ-017 A non-dropped response SHALL write {tag, imem_rdata} into the instruction queue; inst_pc/inst_data present the head entry.
REQ-018 Pop SHALL occur on inst_valid & inst_ready; simultaneous push and pop SHALL leave queue_count unchanged.
REQ-019 Credit accounting SHALL guarantee no push when full; imem_rvalid with outstanding=0 is a protocol error and SHALL be ignored.
REQ-020 Flush SHALL empty the instruction queue the same edge, deassert inst_valid the next cycle and block imem_req in the flush cycle.
REQ-021 On flush, drop_cnt SHALL load outstanding minus (imem_rvalid this cycle); responses while drop_cnt>0 are discarded, decrementing drop_cnt.
REQ-022 Dropped responses SHALL still count against credit until they arrive; after flush, fetching resumes from the redirected pc_in.
REQ-023 Pointers SHALL wrap modulo DEPTH; counts SHALL be clog2(DEPTH)+1 bits and never exceed DEPTH.
REQ-024 Non-bypass latency: a response SHALL appear on inst_valid no earlier than the following cycle.

Reset
REQ-025 While rst=1 the block SHALL hold imem_req=0, stall_out=1 and inst_valid=0, and on the reset edge clear queue_count, outstanding, drop_cnt and all pointers.
REQ-026 A reset mid-operation SHALL abandon in-flight fetches; responses after reset release SHALL be ignored until a new fetch is granted.

Configuration
REQ-027 With IFQ_BYPASS_EN defined, a non-dropped response arriving while the queue is empty and inst_ready=1 SHALL pass to inst_* in the same cycle without a queue write (zero latency).
REQ-028 Without IFQ_BYPASS_EN, every response SHALL pass through the queue (REQ-024 latency of one cycle).

Verification
REQ-029 Streaming: reset at pc_in=0, imem_gnt=1, 1-cycle responses, inst_ready=1 -> inst_pc sequence 0,4,8,12 on consecutive cycles after the initial latency.
REQ-030 Backpressure: inst_ready=0, DEPTH=4 -> exactly 4 grants, then imem_req=0 and stall_out=1; one pop -> one new request.
REQ-031 Flush with 2 outstanding: flush at pc 0x10, redirect pc_in=0x100 -> both old responses dropped, first inst_pc=0x100.
REQ-032 Flush with a response in the same cycle -> that response dropped, drop_cnt=outstanding-1, and no stale inst_valid.
REQ-033 Reset mid-stream with 3 queued entries -> inst_valid=0 and imem_req=0 during rst; counts are 0 after reset.
REQ-034 IFQ_BYPASS_EN: empty queue, inst_ready=1, rvalid with rdata=0x00000013 -> inst_valid=1 with inst_data=0x00000013 in the same cycle.
